// File: rtl/config_shadow_register_bank_pkg.sv
// Shared PWM configuration package: default bank geometry, the commit
// state encoding and a small address range helper used by the bank and
// its shadow memory.
package config_shadow_register_bank_pkg;

   localparam int DefaultAddressSize = 6;
   localparam int DefaultDataSize    = 8;
   localparam int DefaultLocations   = 49;

   // Commit handshake states. A commit request parks the bank in Pending
   // until the next PWM period boundary. Apply then performs the single
   // parallel shadow-to-active copy on the following edge.
   typedef enum logic [1:0] {
      StateIdle    = 2'b00,
      StatePending = 2'b01,
      StateApply   = 2'b10
   } commitState_t;

   // True when an address selects one of the implemented locations.
   function automatic logic isValidAddress(input int unsigned address,
                                           input int unsigned locations);
      return address < locations;
   endfunction

endpackage

// File: rtl/config_shadow_memory.sv
// Shadow configuration storage. It has one write port and one registered
// readback port for the configuration programmer. It also presents every
// location on a flat bus so the active bank can copy them all in one edge.
module config_shadow_memory
   import config_shadow_register_bank_pkg::*;
#(
   parameter int ADDRESS_SIZE = DefaultAddressSize,
   parameter int DATA_SIZE    = DefaultDataSize,
   parameter int LOCATIONS    = DefaultLocations
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [ADDRESS_SIZE-1:0]        i_address,
   input  logic [DATA_SIZE-1:0]           i_data,
   input  logic                           i_write_en,
   output logic [DATA_SIZE-1:0]           o_data,
   output logic [LOCATIONS*DATA_SIZE-1:0] o_flat
);

   logic [DATA_SIZE-1:0] shadowMem [LOCATIONS];
   logic                 addressValid;

   assign addressValid = isValidAddress(32'(i_address), LOCATIONS);

   // Shadow write port. Writes to addresses beyond the implemented
   // locations are dropped silently so that a programmer sweeping the
   // whole address space cannot disturb anything. Reset clears every
   // location.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < LOCATIONS; k++) begin
            shadowMem[k] <= '0;
         end
      end else if (i_write_en && addressValid) begin
         shadowMem[i_address] <= i_data;
      end
   end

   // Registered readback. It only loads on non-write cycles, so the
   // programmer sees the last value it asked for while it is writing.
   // Unimplemented addresses read back as zero.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_data <= '0;
      end else if (!i_write_en) begin
         o_data <= addressValid ? shadowMem[i_address] : '0;
      end
   end

   // Expose every shadow location side by side. The bank uses this for
   // its parallel copy, so location k sits at bits [k*DATA_SIZE +: DATA_SIZE].
   for (genvar k = 0; k < LOCATIONS; k++) begin : g_flat
      assign o_flat[k*DATA_SIZE +: DATA_SIZE] = shadowMem[k];
   end

endmodule

// File: rtl/config_shadow_register_bank.sv
// Double-buffered PWM configuration bank. The programmer writes and reads
// back a shadow copy at will. The active copy seen by the PWM datapath only
// changes when a commit has been requested and a period boundary arrives.
// This keeps the new settings from tearing in the middle of a PWM period.
module config_shadow_register_bank
   import config_shadow_register_bank_pkg::*;
#(
   parameter int ADDRESS_SIZE = DefaultAddressSize,
   parameter int DATA_SIZE    = DefaultDataSize,
   parameter int LOCATIONS    = DefaultLocations
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [ADDRESS_SIZE-1:0]        i_address,
   input  logic [DATA_SIZE-1:0]           i_data,
   input  logic                           i_write_en,
   input  logic                           i_commit,
   input  logic                           i_period_end,
   output logic [DATA_SIZE-1:0]           o_data,
   output logic [LOCATIONS*DATA_SIZE-1:0] o_active,
   output logic                           o_pending,
   output logic                           o_commit_done
);

   commitState_t                   state;
   logic [LOCATIONS*DATA_SIZE-1:0] shadowFlat;

   config_shadow_memory #(
      .ADDRESS_SIZE (ADDRESS_SIZE),
      .DATA_SIZE    (DATA_SIZE),
      .LOCATIONS    (LOCATIONS)
   ) u_shadow (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_address  (i_address),
      .i_data     (i_data),
      .i_write_en (i_write_en),
      .o_data     (o_data),
      .o_flat     (shadowFlat)
   );

   // Commit sequencing. A period boundary while Idle means nothing, even
   // when it lands together with the commit request. A second commit
   // while Pending is not queued. A commit seen during Apply re-arms
   // straight back into Pending, so a request made in that cycle is not
   // lost. Reset wins over everything and abandons any commit in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= StateIdle;
      end else begin
         case (state)
            StateIdle: begin
               if (i_commit) begin
                  state <= StatePending;
               end
            end
            StatePending: begin
               if (i_period_end) begin
                  state <= StateApply;
               end
            end
            StateApply: begin
               state <= i_commit ? StatePending : StateIdle;
            end
            default: begin
               state <= StateIdle;
            end
         endcase
      end
   end

   // Active bank update. The copy happens on the edge that leaves Apply.
   // It takes the registered shadow contents, so a write landing on that
   // same edge only reaches the shadow and waits for the next commit. The
   // done pulse rises on the copy edge and lasts exactly one cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_active      <= '0;
         o_commit_done <= 1'b0;
      end else begin
         o_commit_done <= (state == StateApply);
         if (state == StateApply) begin
            o_active <= shadowFlat;
         end
      end
   end

   // A commit counts as outstanding from acceptance until the copy has
   // actually been performed.
   assign o_pending = (state != StateIdle);

endmodule

// File: tb/tb_config_shadow_register_bank.sv
// Self-checking bench for config_shadow_register_bank. Directed scenarios
// exercise the readback, range and commit timing corners. A randomized run
// follows, compared every cycle against a behavioural model of the bank.
module tb_config_shadow_register_bank;

   localparam int AddrW = 6;
   localparam int DataW = 8;
   localparam int Locs  = 49;
   localparam int FlatW = Locs * DataW;

   logic             clock;
   logic             reset;
   logic [AddrW-1:0] address;
   logic [DataW-1:0] dataIn;
   logic             writeEn;
   logic             commit;
   logic             periodEnd;
   logic [DataW-1:0] dataOut;
   logic [FlatW-1:0] active;
   logic             pending;
   logic             commitDone;

   int compared   = 0;
   int mismatched = 0;

   logic [DataW-1:0] modelShadow [Locs];
   logic [DataW-1:0] modelActive [Locs];
   logic [DataW-1:0] modelData;
   bit               modelDone;
   bit               modelWaiting;
   bit               modelCopyDue;

   config_shadow_register_bank #(
      .ADDRESS_SIZE (AddrW),
      .DATA_SIZE    (DataW),
      .LOCATIONS    (Locs)
   ) dut (
      .i_clk         (clock),
      .i_reset       (reset),
      .i_address     (address),
      .i_data        (dataIn),
      .i_write_en    (writeEn),
      .i_commit      (commit),
      .i_period_end  (periodEnd),
      .o_data        (dataOut),
      .o_active      (active),
      .o_pending     (pending),
      .o_commit_done (commitDone)
   );

   // Free-running clock with a 10 ns period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Packs the model's active bank into the same layout as o_active.
   function automatic logic [FlatW-1:0] modelActiveFlat();
      logic [FlatW-1:0] flat;
      flat = '0;
      for (int k = 0; k < Locs; k++) begin
         flat[k*DataW +: DataW] = modelActive[k];
      end
      return flat;
   endfunction

   // Advances the behavioural model by one clock edge. A requested commit
   // waits for a boundary, and the copy happens one edge later. The copy
   // reads the shadow as it was before any write on the same edge.
   function automatic void modelEdge(input bit rst, input bit we, input bit cm,
                                     input bit pe, input logic [AddrW-1:0] a,
                                     input logic [DataW-1:0] d);
      if (rst) begin
         for (int k = 0; k < Locs; k++) begin
            modelShadow[k] = '0;
            modelActive[k] = '0;
         end
         modelData    = '0;
         modelDone    = 1'b0;
         modelWaiting = 1'b0;
         modelCopyDue = 1'b0;
         return;
      end
      modelDone = 1'b0;
      if (modelCopyDue) begin
         for (int k = 0; k < Locs; k++) modelActive[k] = modelShadow[k];
         modelDone    = 1'b1;
         modelCopyDue = 1'b0;
         modelWaiting = cm;
      end else if (modelWaiting) begin
         if (pe) begin
            modelWaiting = 1'b0;
            modelCopyDue = 1'b1;
         end
      end else if (cm) begin
         modelWaiting = 1'b1;
      end
      if (we) begin
         if (int'(a) < Locs) modelShadow[int'(a)] = d;
      end else begin
         modelData = (int'(a) < Locs) ? modelShadow[int'(a)] : '0;
      end
   endfunction

   // One comparison: counts it, and on disagreement counts a failure and reports it.
   task automatic checkValue(input string tag, input logic [FlatW-1:0] observed,
                             input logic [FlatW-1:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compares every DUT output against the model after an edge.
   task automatic checkOutput(input string tag);
      checkValue({tag, ".data"},    FlatW'(dataOut),    FlatW'(modelData));
      checkValue({tag, ".pending"}, FlatW'(pending),    FlatW'(modelWaiting || modelCopyDue));
      checkValue({tag, ".done"},    FlatW'(commitDone), FlatW'(modelDone));
      checkValue({tag, ".active"},  active,             modelActiveFlat());
   endtask

   // Drives one cycle of inputs and steps the model on the edge. It then
   // checks the DUT a little after the edge.
   task automatic applyStimulus(input string tag, input bit rst, input bit we,
                                input bit cm, input bit pe,
                                input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
      reset     = rst;
      writeEn   = we;
      commit    = cm;
      periodEnd = pe;
      address   = a;
      dataIn    = d;
      @(posedge clock);
      modelEdge(rst, we, cm, pe, a, d);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      int pendingCycles;
      int doneCycles;
      bit rRst, rWe, rCm, rPe;
      logic [AddrW-1:0] rAddr;
      logic [DataW-1:0] rData;

      reset = 1'b1; writeEn = 1'b0; commit = 1'b0; periodEnd = 1'b0;
      address = '0; dataIn = '0;

      $display("[TB] reset and basic readback");
      applyStimulus("reset", 1, 0, 0, 0, 6'd0, 8'h00);
      checkValue("resetActive", active, '0);
      applyStimulus("wr3", 0, 1, 0, 0, 6'd3, 8'hA5);
      applyStimulus("rd3", 0, 0, 0, 0, 6'd3, 8'h00);
      checkValue("rd3Value", FlatW'(dataOut), FlatW'(8'hA5));
      checkValue("active3Untouched", FlatW'(active[3*DataW +: DataW]), FlatW'(8'h00));

      $display("[TB] address range edge");
      applyStimulus("wr48", 0, 1, 0, 0, 6'd48, 8'h5A);
      applyStimulus("wr49", 0, 1, 0, 0, 6'd49, 8'h5A);
      applyStimulus("rd48", 0, 0, 0, 0, 6'd48, 8'h00);
      checkValue("rd48Value", FlatW'(dataOut), FlatW'(8'h5A));
      applyStimulus("rd49", 0, 0, 0, 0, 6'd49, 8'h00);
      checkValue("rd49Value", FlatW'(dataOut), FlatW'(8'h00));
      applyStimulus("rd3Again", 0, 0, 0, 0, 6'd3, 8'h00);
      checkValue("rd3Kept", FlatW'(dataOut), FlatW'(8'hA5));

      $display("[TB] commit waiting ten cycles for a boundary");
      pendingCycles = 0;
      doneCycles    = 0;
      applyStimulus("commitReq", 0, 0, 1, 0, 6'd0, 8'h00);
      pendingCycles += int'(pending); doneCycles += int'(commitDone);
      for (int i = 0; i < 9; i++) begin
         applyStimulus("waitBoundary", 0, 0, 0, 0, 6'd0, 8'h00);
         pendingCycles += int'(pending); doneCycles += int'(commitDone);
      end
      applyStimulus("boundary", 0, 0, 0, 1, 6'd0, 8'h00);
      pendingCycles += int'(pending); doneCycles += int'(commitDone);
      applyStimulus("copyEdge", 0, 0, 0, 0, 6'd0, 8'h00);
      pendingCycles += int'(pending); doneCycles += int'(commitDone);
      applyStimulus("afterCopy", 0, 0, 0, 0, 6'd0, 8'h00);
      pendingCycles += int'(pending); doneCycles += int'(commitDone);
      checkValue("pendingCycles", FlatW'(pendingCycles), FlatW'(11));
      checkValue("donePulses", FlatW'(doneCycles), FlatW'(1));
      checkValue("active48", FlatW'(active[48*DataW +: DataW]), FlatW'(8'h5A));

      $display("[TB] write colliding with the copy");
      applyStimulus("commit2", 0, 0, 1, 0, 6'd0, 8'h00);
      applyStimulus("boundary2", 0, 0, 0, 1, 6'd0, 8'h00);
      applyStimulus("wrDuringApply", 0, 1, 0, 0, 6'd3, 8'h11);
      checkValue("active3Old", FlatW'(active[3*DataW +: DataW]), FlatW'(8'hA5));
      applyStimulus("rd3New", 0, 0, 0, 0, 6'd3, 8'h00);
      checkValue("shadow3New", FlatW'(dataOut), FlatW'(8'h11));
      applyStimulus("commit3", 0, 0, 1, 0, 6'd0, 8'h00);
      applyStimulus("boundary3", 0, 0, 0, 1, 6'd0, 8'h00);
      applyStimulus("copy3", 0, 0, 0, 0, 6'd0, 8'h00);
      checkValue("active3New", FlatW'(active[3*DataW +: DataW]), FlatW'(8'h11));

      $display("[TB] reset aborting a pending commit");
      applyStimulus("wr7", 0, 1, 0, 0, 6'd7, 8'h77);
      applyStimulus("commit4", 0, 0, 1, 0, 6'd0, 8'h00);
      applyStimulus("resetPending", 1, 0, 0, 1, 6'd0, 8'h00);
      checkValue("resetPendingLow", FlatW'(pending), FlatW'(0));
      checkValue("resetActiveZero", active, '0);
      applyStimulus("postReset", 0, 0, 0, 1, 6'd7, 8'h00);
      checkValue("postResetNoDone", FlatW'(commitDone), FlatW'(0));

      $display("[TB] commit and boundary in the same cycle");
      applyStimulus("wr9", 0, 1, 0, 0, 6'd9, 8'h3C);
      applyStimulus("commitAndBoundary", 0, 0, 1, 1, 6'd0, 8'h00);
      checkValue("sameCyclePending", FlatW'(pending), FlatW'(1));
      for (int i = 0; i < 3; i++) begin
         applyStimulus("holdPending", 0, 0, 0, 0, 6'd0, 8'h00);
      end
      checkValue("noEarlyCopy", FlatW'(active[9*DataW +: DataW]), FlatW'(8'h00));
      applyStimulus("boundary5", 0, 0, 0, 1, 6'd0, 8'h00);
      applyStimulus("copy5", 0, 0, 0, 0, 6'd0, 8'h00);
      checkValue("active9", FlatW'(active[9*DataW +: DataW]), FlatW'(8'h3C));

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         rRst  = ($urandom_range(0, 79) == 0);
         rWe   = ($urandom_range(0, 1) == 1);
         rCm   = ($urandom_range(0, 5) == 0);
         rPe   = ($urandom_range(0, 4) == 0);
         rAddr = AddrW'($urandom_range(0, 63));
         rData = DataW'($urandom_range(0, 255));
         applyStimulus("random", rRst, rWe, rCm, rPe, rAddr, rData);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/config_shadow_register_bank.md
CONFIG_SHADOW_REGISTER_BANK -- requirements
Module: config_shadow_register_bank

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 6, width of the configuration address.
REQ-002 SHALL have parameter DATA_SIZE, default 8, width of one configuration byte.
REQ-003 SHALL have parameter LOCATIONS, default 49, number of configuration registers.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_address, input, ADDRESS_SIZE, write and readback address from the configuration programmer.
REQ-007 SHALL have port i_data, input, DATA_SIZE, write data.
REQ-008 SHALL have port i_write_en, input, 1: 1 = write cycle, 0 = readback cycle.
REQ-009 SHALL have port i_commit, input, 1, single-cycle request to transfer shadow to active.
REQ-010 SHALL have port i_period_end, input, 1, single-cycle PWM period boundary strobe.
REQ-011 SHALL have port o_data, output, DATA_SIZE, registered readback of the shadow register.
REQ-012 SHALL have port o_active, output, LOCATIONS*DATA_SIZE, flattened active registers; location k occupies bits [k*DATA_SIZE +: DATA_SIZE].
REQ-013 SHALL have port o_pending, output, 1, high while a commit waits for a period boundary.
REQ-014 SHALL have port o_commit_done, output, 1, one-cycle pulse after active is updated.

Function
REQ-015 SHALL write i_data into shadow[i_address] on the clock edge when i_write_en=1 and i_address<LOCATIONS; writes to i_address>=LOCATIONS SHALL be ignored.
REQ-016 SHALL, when i_write_en=0, load o_data with shadow[i_address] (latency 1 cycle); i_address>=LOCATIONS SHALL return 0; o_data SHALL hold its value during write cycles.
REQ-017 SHALL implement FSM states IDLE, PENDING, APPLY.
REQ-018 IDLE->PENDING on i_commit=1; i_period_end in IDLE SHALL have no effect, including when it coincides with i_commit.
REQ-019 PENDING->APPLY on i_period_end=1; i_commit in PENDING SHALL be ignored (no queuing).
REQ-020 In APPLY, the next edge SHALL copy all shadow locations to active in parallel, pulse o_commit_done for exactly that following cycle, and go to IDLE, or to PENDING if i_commit=1 during APPLY.
REQ-021 A write in the same cycle as the APPLY copy SHALL update shadow only; active SHALL receive the pre-write shadow value.
REQ-022 o_pending SHALL equal 1 in PENDING and APPLY, 0 in IDLE.
REQ-023 o_active SHALL change only on the APPLY copy edge and on reset.

Reset
REQ-024 On i_clk edge with i_reset=1: all shadow and active locations 0, o_data 0, state IDLE, o_pending 0, o_commit_done 0.
REQ-025 Reset SHALL abort any pending or in-progress commit with no partial copy; reset SHALL take priority over write, commit and period_end.

Structure
REQ-026 The FSM state encoding and default LOCATIONS/DATA_SIZE/ADDRESS_SIZE SHALL be constants in the shared pwm configuration package.
REQ-027 The shadow array SHALL be a sub-module config_shadow_memory (write port, registered read port, flat parallel output); the FSM and active registers SHALL live in the top.

Verification
REQ-028 Reset, write 0xA5 to address 3, readback address 3 -> o_data=0xA5 one cycle later; o_active location 3 still 0x00.
REQ-029 Write 0x5A to address 48 and address 49 -> readback 48=0x5A, readback 49=0x00, no other location changed.
REQ-030 i_commit, then i_period_end 10 cycles later -> o_pending high for 11 cycles; o_commit_done pulses once on the cycle after the copy edge; o_active location 48=0x5A.
REQ-031 Write 0x11 to address 3 in the APPLY cycle -> active location 3=0xA5, shadow location 3=0x11; a second commit and period_end -> active location 3=0x11.
REQ-032 i_reset asserted during PENDING -> state IDLE, o_pending 0, o_active all 0, no o_commit_done pulse.
REQ-033 i_commit and i_period_end in the same cycle from IDLE -> PENDING; no copy until the next i_period_end.
